// File: rtl/traffic_safety_monitor.sv
// traffic_safety_monitor
//
// Conflict monitor placed between the 4-way traffic light sequencer and the
// lamp drivers. Each cycle it samples the four 3-bit approach codes
// (RED=100, YELLOW=010, GREEN=001) and forwards them, registered, to the lamps.
// It checks encoding, mutual exclusion, per-approach sequence, yellow dwell and
// liveness. On any violation it latches a fault and flashes all lamps red
// until fault_clr is asserted.
//
// Optional feature: define TSM_FAULT_COUNT_EN to add fault_count, a saturating
// count of RUN->FAULT entries that only rst clears.
//
// Ports:
//   clk                         system clock
//   rst                         synchronous active-high reset
//   north/east/south/west_in    upstream approach codes
//   fault_clr                   request to leave FAULT (ignored elsewhere)
//   north/east/south/west_out   registered lamp drive
//   fault                       high while in FAULT
//   fault_code                  latched cause: 0 none, 1 encoding, 2 conflict,
//                               3 sequence, 4 short yellow, 5 watchdog
//   fault_count                 (TSM_FAULT_COUNT_EN only) fault entries, sat. 255
module traffic_safety_monitor #(
  parameter int unsigned STARTUP_CYCLES = 4,
  parameter int unsigned MIN_YELLOW     = 1,
  parameter int unsigned WATCHDOG       = 16,
  parameter int unsigned FLASH_HALF     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] north_in,
  input  logic [2:0] east_in,
  input  logic [2:0] south_in,
  input  logic [2:0] west_in,
  input  logic       fault_clr,
  output logic [2:0] north_out,
  output logic [2:0] east_out,
  output logic [2:0] south_out,
  output logic [2:0] west_out,
  output logic       fault,
  output logic [2:0] fault_code
`ifdef TSM_FAULT_COUNT_EN
  ,
  output logic [7:0] fault_count
`endif
);

  localparam logic [2:0]  Red    = 3'b100;
  localparam logic [2:0]  Yellow = 3'b010;
  localparam logic [2:0]  Green  = 3'b001;
  localparam logic [11:0] AllRed = {Red, Red, Red, Red};

  localparam int unsigned StartW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int unsigned StallW = $clog2(WATCHDOG + 1);
  localparam int unsigned YelW   = (MIN_YELLOW > 0) ? $clog2(MIN_YELLOW + 1) : 1;
  localparam int unsigned FlashW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [StartW-1:0] StartLast = StartW'(STARTUP_CYCLES - 1);
  localparam logic [StallW-1:0] StallMax  = StallW'(WATCHDOG);
  localparam logic [YelW-1:0]   YelMax    = YelW'(MIN_YELLOW);
  localparam logic [FlashW-1:0] FlashLast = FlashW'(FLASH_HALF - 1);

  typedef enum logic [1:0] {StStartup, StRun, StFault} state_e;

  state_e            state_q, state_d;
  logic [3:0][2:0]   in_vec;
  logic [3:0][2:0]   prev_q, prev_d;
  logic [3:0][2:0]   out_q, out_d;
  logic              fault_q, fault_d;
  logic [2:0]        code_q, code_d;
  logic [StartW-1:0] start_q, start_d;
  logic [StallW-1:0] stall_q, stall_d, stall_nx;
  logic [3:0][YelW-1:0] yel_q, yel_d, yel_nx;
  logic [FlashW-1:0] flash_q, flash_d;
  logic              flash_off_q, flash_off_d;

  logic              enc_err, conflict_err, seq_err, short_err, wd_err;
  logic [2:0]        non_red_cnt;
  logic [2:0]        code_chk;

`ifdef TSM_FAULT_COUNT_EN
  logic [7:0]        count_q, count_d;
`endif

  // Index 0 is North, 3 is West.
  assign in_vec = {west_in, south_in, east_in, north_in};

  // Violation detection on the current sample against the previous one.
  always_comb begin
    enc_err     = 1'b0;
    seq_err     = 1'b0;
    short_err   = 1'b0;
    non_red_cnt = 3'd0;
    yel_nx      = '0;
    for (int i = 0; i < 4; i++) begin
      if (!(in_vec[i] == Red || in_vec[i] == Yellow || in_vec[i] == Green)) begin
        enc_err = 1'b1;
      end
      if (in_vec[i] != Red) begin
        non_red_cnt = non_red_cnt + 3'd1;
      end
      if (in_vec[i] != prev_q[i] &&
          !((prev_q[i] == Red    && in_vec[i] == Green)  ||
            (prev_q[i] == Green  && in_vec[i] == Yellow) ||
            (prev_q[i] == Yellow && in_vec[i] == Red))) begin
        seq_err = 1'b1;
      end
      // yel_q counts yellow samples up to and including the previous one.
      if (prev_q[i] == Yellow && in_vec[i] == Red && yel_q[i] < YelMax) begin
        short_err = 1'b1;
      end
      if (in_vec[i] == Yellow) begin
        yel_nx[i] = (yel_q[i] == YelMax) ? YelMax : yel_q[i] + YelW'(1);
      end
    end
    conflict_err = (non_red_cnt > 3'd1);

    if (in_vec != prev_q) begin
      stall_nx = '0;
    end else begin
      stall_nx = (stall_q == StallMax) ? StallMax : stall_q + StallW'(1);
    end
    wd_err = (stall_nx == StallMax);

    // Lowest code wins on simultaneous violations.
    if (enc_err) begin
      code_chk = 3'd1;
    end else if (conflict_err) begin
      code_chk = 3'd2;
    end else if (seq_err) begin
      code_chk = 3'd3;
    end else if (short_err) begin
      code_chk = 3'd4;
    end else if (wd_err) begin
      code_chk = 3'd5;
    end else begin
      code_chk = 3'd0;
    end
  end

  // Next-state and registered outputs.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    fault_d     = fault_q;
    code_d      = code_q;
    start_d     = start_q;
    stall_d     = stall_q;
    flash_d     = flash_q;
    flash_off_d = flash_off_q;
    yel_d       = yel_nx;
    prev_d      = in_vec;
`ifdef TSM_FAULT_COUNT_EN
    count_d     = count_q;
`endif

    case (state_q)
      StStartup: begin
        out_d   = AllRed;
        stall_d = '0;
        if (start_q == StartLast) begin
          state_d = StRun;
          start_d = '0;
        end else begin
          start_d = start_q + StartW'(1);
        end
      end

      StRun: begin
        if (code_chk != 3'd0) begin
          // The offending sample is replaced by all-red on this same edge.
          state_d     = StFault;
          fault_d     = 1'b1;
          code_d      = code_chk;
          out_d       = AllRed;
          flash_d     = '0;
          flash_off_d = 1'b0;
`ifdef TSM_FAULT_COUNT_EN
          if (count_q != 8'hff) begin
            count_d = count_q + 8'd1;
          end
`endif
        end else begin
          out_d   = in_vec;
          stall_d = stall_nx;
        end
      end

      StFault: begin
        if (fault_clr) begin
          state_d     = StStartup;
          fault_d     = 1'b0;
          code_d      = 3'd0;
          out_d       = AllRed;
          start_d     = '0;
          stall_d     = '0;
          flash_d     = '0;
          flash_off_d = 1'b0;
          yel_d       = '0;
        end else begin
          if (flash_q == FlashLast) begin
            flash_d     = '0;
            flash_off_d = !flash_off_q;
          end else begin
            flash_d = flash_q + FlashW'(1);
          end
          out_d = flash_off_d ? 12'h000 : AllRed;
        end
      end

      default: begin
        state_d = StStartup;
        out_d   = AllRed;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StStartup;
      out_q       <= AllRed;
      fault_q     <= 1'b0;
      code_q      <= 3'd0;
      start_q     <= '0;
      stall_q     <= '0;
      flash_q     <= '0;
      flash_off_q <= 1'b0;
      yel_q       <= '0;
      prev_q      <= AllRed;
`ifdef TSM_FAULT_COUNT_EN
      count_q     <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      start_q     <= start_d;
      stall_q     <= stall_d;
      flash_q     <= flash_d;
      flash_off_q <= flash_off_d;
      yel_q       <= yel_d;
      prev_q      <= prev_d;
`ifdef TSM_FAULT_COUNT_EN
      count_q     <= count_d;
`endif
    end
  end

  assign north_out  = out_q[0];
  assign east_out   = out_q[1];
  assign south_out  = out_q[2];
  assign west_out   = out_q[3];
  assign fault      = fault_q;
  assign fault_code = code_q;
`ifdef TSM_FAULT_COUNT_EN
  assign fault_count = count_q;
`endif

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Self-checking bench for traffic_safety_monitor: directed scenarios followed by
// randomized legal traffic with injected violations, all compared every cycle
// against a cycle-level behavioural model of the monitor.
module tb_traffic_safety_monitor;

  localparam int unsigned TbStartup   = 4;
  localparam int unsigned TbMinYellow = 2;
  localparam int unsigned TbWatchdog  = 16;
  localparam int unsigned TbFlashHalf = 2;

  typedef logic [3:0][2:0] vec_t;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam vec_t AllR = {R, R, R, R};
  localparam vec_t AllD = '0;

  localparam int MStartup = 0;
  localparam int MRun     = 1;
  localparam int MFault   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] north_in, east_in, south_in, west_in;
  logic       fault_clr;
  logic [2:0] north_out, east_out, south_out, west_out;
  logic       fault;
  logic [2:0] fault_code;
`ifdef TSM_FAULT_COUNT_EN
  logic [7:0] fault_count;
`endif
  vec_t       dut_out;

  int n_checks;
  int n_errors;

  // Behavioural model state.
  int   m_mode;
  int   m_startup_seen;
  int   m_stall;
  int   m_age;
  int   m_yel [4];
  vec_t m_prev;
  vec_t exp_out;
  logic exp_fault;
  int   exp_code;
  int   exp_count;

  // Legal-traffic generator state.
  int   gen_app;
  int   gen_ph;
  int   gen_left;
  vec_t last_vec;

  logic [2:0] bad_codes [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
  bit         flash_tab [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  traffic_safety_monitor #(
    .STARTUP_CYCLES(TbStartup),
    .MIN_YELLOW    (TbMinYellow),
    .WATCHDOG      (TbWatchdog),
    .FLASH_HALF    (TbFlashHalf)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .north_in   (north_in),
    .east_in    (east_in),
    .south_in   (south_in),
    .west_in    (west_in),
    .fault_clr  (fault_clr),
    .north_out  (north_out),
    .east_out   (east_out),
    .south_out  (south_out),
    .west_out   (west_out),
    .fault      (fault),
`ifdef TSM_FAULT_COUNT_EN
    .fault_count(fault_count),
`endif
    .fault_code (fault_code)
  );

  assign dut_out = {west_out, south_out, east_out, north_out};

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  // One clock edge of the monitor as described by its rules.
  task automatic model_step(input vec_t v, input logic clr, input logic r);
    int   new_yel [4];
    int   code;
    int   non_red;
    int   stall_next;
    bit   enc, seq, short_y;
    if (r) begin
      m_mode         = MStartup;
      m_startup_seen = 0;
      m_stall        = 0;
      for (int i = 0; i < 4; i++) m_yel[i] = 0;
      m_prev    = AllR;
      exp_out   = AllR;
      exp_fault = 1'b0;
      exp_code  = 0;
      exp_count = 0;
      return;
    end
    for (int i = 0; i < 4; i++) new_yel[i] = (v[i] == Y) ? m_yel[i] + 1 : 0;
    case (m_mode)
      MStartup: begin
        exp_out = AllR;
        m_startup_seen++;
        if (m_startup_seen >= int'(TbStartup)) begin
          m_mode  = MRun;
          m_stall = 0;
        end
      end
      MRun: begin
        enc = 0; seq = 0; short_y = 0; non_red = 0;
        for (int i = 0; i < 4; i++) begin
          if (v[i] != R && v[i] != Y && v[i] != G) enc = 1;
          if (v[i] != R) non_red++;
          if (v[i] != m_prev[i] &&
              !((m_prev[i] == R && v[i] == G) || (m_prev[i] == G && v[i] == Y) ||
                (m_prev[i] == Y && v[i] == R))) seq = 1;
          if (m_prev[i] == Y && v[i] == R && m_yel[i] < int'(TbMinYellow)) short_y = 1;
        end
        stall_next = (v != m_prev) ? 0 : m_stall + 1;
        if (enc)                                 code = 1;
        else if (non_red > 1)                    code = 2;
        else if (seq)                            code = 3;
        else if (short_y)                        code = 4;
        else if (stall_next >= int'(TbWatchdog)) code = 5;
        else                                     code = 0;
        if (code != 0) begin
          m_mode    = MFault;
          m_age     = 0;
          exp_fault = 1'b1;
          exp_code  = code;
          exp_out   = AllR;
          if (exp_count < 255) exp_count++;
        end else begin
          exp_out = v;
          m_stall = stall_next;
        end
      end
      default: begin
        if (clr) begin
          m_mode         = MStartup;
          m_startup_seen = 0;
          exp_fault      = 1'b0;
          exp_code       = 0;
          exp_out        = AllR;
          for (int i = 0; i < 4; i++) new_yel[i] = 0;
        end else begin
          m_age++;
          exp_out = (((m_age / int'(TbFlashHalf)) % 2) != 0) ? AllD : AllR;
        end
      end
    endcase
    m_prev = v;
    for (int i = 0; i < 4; i++) m_yel[i] = new_yel[i];
  endtask

  task automatic step(input vec_t v, input logic clr, input logic r);
    north_in  = v[0];
    east_in   = v[1];
    south_in  = v[2];
    west_in   = v[3];
    fault_clr = clr;
    rst       = r;
    model_step(v, clr, r);
    @(posedge clk);
    #1;
    check_val("lamps", 32'(dut_out), 32'(exp_out));
    check_val("fault", 32'(fault), 32'(exp_fault));
    check_val("fault_code", 32'(fault_code), 32'(exp_code));
`ifdef TSM_FAULT_COUNT_EN
    check_val("fault_count", 32'(fault_count), 32'(exp_count));
`endif
    last_vec = v;
  endtask

  // Clear a fault and sit in all-red until RUN, leaving a red previous sample.
  task automatic recover();
    step(last_vec, 1'b1, 1'b0);
    repeat (TbStartup) step(AllR, 1'b0, 1'b0);
  endtask

  task automatic gen_next(output vec_t v);
    v = AllR;
    if (gen_ph == 1) v[gen_app] = G;
    else if (gen_ph == 2) v[gen_app] = Y;
    gen_left--;
    if (gen_left <= 0) begin
      case (gen_ph)
        0: begin gen_ph = 1; gen_left = int'($urandom_range(1, 3)); end
        1: begin gen_ph = 2; gen_left = int'($urandom_range(1, 4)); end
        default: begin
          gen_ph   = 0;
          gen_left = int'($urandom_range(1, 2));
          gen_app  = (gen_app + 1) % 4;
        end
      endcase
    end
  endtask

  task automatic inject(inout vec_t v);
    int a;
    int kind;
    int b;
    kind = int'($urandom_range(1, 3));
    a    = int'($urandom_range(0, 3));
    case (kind)
      1: begin b = int'($urandom_range(0, 4)); v[a] = bad_codes[b]; end
      2: begin v[a] = G; v[(a + 1) % 4] = G; end
      default: begin
        if (last_vec[a] == R)      v[a] = Y;
        else if (last_vec[a] == G) v[a] = R;
        else                       v[a] = G;
      end
    endcase
  endtask

  initial begin
    vec_t v;
    logic clr_r;
    logic rst_r;
    n_checks = 0;
    n_errors = 0;
    gen_app  = 0;
    gen_ph   = 0;
    gen_left = 1;
    last_vec = AllR;

    // Reset state.
    step(AllR, 1'b0, 1'b1);
    check_val("rst_lamps", 32'(dut_out), 32'(AllR));
    check_val("rst_fault", 32'(fault), 32'd0);
    check_val("rst_code", 32'(fault_code), 32'd0);

    // Legal rotation straight out of reset, each yellow held for the minimum.
    for (int t = 0; t < 34; t++) begin
      for (int k = 0; k < 3; k++) begin
        v = AllR;
        v[t % 4] = (k == 0) ? G : Y;
        step(v, 1'b0, 1'b0);
        if (t * 3 + k < int'(TbStartup)) check_val("startup_red", 32'(dut_out), 32'(AllR));
        else check_val("forward", 32'(dut_out), 32'(v));
      end
    end
    check_val("rotation_no_fault", 32'(fault), 32'd0);
    step(AllR, 1'b0, 1'b0);

    // Conflict, then the flash pattern.
    v = AllR; v[0] = G; v[1] = G;
    step(v, 1'b0, 1'b0);
    check_val("conflict_code", 32'(fault_code), 32'd2);
    check_val("conflict_lamps", 32'(dut_out), 32'(AllR));
    for (int k = 1; k < 8; k++) begin
      step(AllR, 1'b0, 1'b0);
      check_val("flash", 32'(dut_out), flash_tab[k] ? 32'(AllR) : 32'(AllD));
    end
    recover();

    // Green straight to red.
    v = AllR; v[0] = G; step(v, 1'b0, 1'b0);
    v[0] = R; step(v, 1'b0, 1'b0);
    check_val("sequence_code", 32'(fault_code), 32'd3);
    recover();

    // Bad encoding together with a conflict: encoding wins.
    v = AllR; v[0] = 3'b011; v[1] = G;
    step(v, 1'b0, 1'b0);
    check_val("encoding_priority", 32'(fault_code), 32'd1);
    recover();
`ifdef TSM_FAULT_COUNT_EN
    check_val("count_after_three", 32'(fault_count), 32'd3);
`endif

    // Yellow one cycle short of the minimum.
    v = AllR; v[0] = G; step(v, 1'b0, 1'b0);
    v[0] = Y; step(v, 1'b0, 1'b0);
    v[0] = R; step(v, 1'b0, 1'b0);
    check_val("short_yellow_code", 32'(fault_code), 32'd4);
    recover();

    // Yellow held exactly the minimum.
    v = AllR; v[0] = G; step(v, 1'b0, 1'b0);
    v[0] = Y; step(v, 1'b0, 1'b0); step(v, 1'b0, 1'b0);
    v[0] = R; step(v, 1'b0, 1'b0);
    check_val("min_yellow_ok", 32'(fault), 32'd0);

    // Frozen inputs trip the watchdog, then clear and resume.
    v = AllR; v[0] = G;
    step(v, 1'b0, 1'b0);
    repeat (TbWatchdog - 1) step(v, 1'b0, 1'b0);
    check_val("watchdog_early", 32'(fault), 32'd0);
    step(v, 1'b0, 1'b0);
    check_val("watchdog_code", 32'(fault_code), 32'd5);
    step(v, 1'b1, 1'b0);
    check_val("clear_fault", 32'(fault), 32'd0);
    check_val("clear_code", 32'(fault_code), 32'd0);
    for (int k = 0; k < int'(TbStartup); k++) begin
      step(v, 1'b0, 1'b0);
      check_val("restart_red", 32'(dut_out), 32'(AllR));
    end
    v[0] = Y;
    step(v, 1'b0, 1'b0);
    check_val("resume_forward", 32'(dut_out), 32'(v));
    step(v, 1'b0, 1'b0);
    step(AllR, 1'b0, 1'b0);

    // Reset during the dark half of the flash.
    v = AllR; v[0] = G; v[1] = G;
    step(v, 1'b0, 1'b0);
    step(AllR, 1'b0, 1'b0);
    step(AllR, 1'b0, 1'b0);
    check_val("flash_off_phase", 32'(dut_out), 32'(AllD));
    step(AllR, 1'b0, 1'b1);
    check_val("rst_in_fault_lamps", 32'(dut_out), 32'(AllR));
    check_val("rst_in_fault_flag", 32'(fault), 32'd0);
    check_val("rst_in_fault_code", 32'(fault_code), 32'd0);

    // Randomized legal traffic with injected violations, clears and resets.
    for (int c = 0; c < 1500; c++) begin
      gen_next(v);
      clr_r = ($urandom_range(0, 7) == 0);
      rst_r = ($urandom_range(0, 199) == 0);
      if (m_mode == MRun && $urandom_range(0, 11) == 0) inject(v);
      step(v, clr_r, rst_r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
